// File: rtl/pe_pkg.sv
// Shared definitions for the priority encoder / round-robin arbiter.
package pe_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/pe_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface pe_rr_arbiter_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic         mode;
   logic [N-1:0] req;
   logic         grant_ready;
   logic         grant_valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_onehot;

   modport master (
      output mode,
      output req,
      output grant_ready,
      input  grant_valid,
      input  grant_idx,
      input  grant_onehot
   );

   modport slave (
      input  mode,
      input  req,
      input  grant_ready,
      output grant_valid,
      output grant_idx,
      output grant_onehot
   );
endinterface

// File: rtl/pe_prio_pick.sv
// Combinational highest-set-bit finder: index of the top set bit plus found flag.
module pe_prio_pick #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   // Ascending scan so the last (highest) set bit overwrites earlier hits.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_rr_arbiter.sv
// Registered priority arbiter with fixed and round-robin modes under valid/ready.
module pe_rr_arbiter
   import pe_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   pe_rr_arbiter_if.slave    bus
);

   state_t       state_reg;
   logic [W-1:0] ptr_reg;
   logic         valid_reg;
   logic [W-1:0] idx_reg;
   logic [N-1:0] onehot_reg;

   logic [W-1:0] rot_amt;
   logic [N-1:0] rot_req;
   logic [W-1:0] pick_idx;
   logic         pick_found;
   logic [W-1:0] win_idx;
   logic         decision;

   // (a + b) mod N for operands already below N; one extra bit covers the carry.
   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (W+1)'(N)) s = s - (W+1)'(N);
      return s[W-1:0];
   endfunction

   // Fixed mode uses zero rotation so the picker sees req unchanged.
   assign rot_amt = (bus.mode == MODE_RR) ? ptr_reg : '0;

   // Rotated bit j holds req[(j + ptr) mod N], so ptr-1 lands on the top
   // (highest priority) position and ptr itself on the bottom.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rot_req[gi] = bus.req[mod_add(W'(gi), rot_amt)];
   end

   pe_prio_pick #(.N(N)) u_pick (
      .vec   (rot_req),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign win_idx  = mod_add(pick_idx, rot_amt);
   assign decision = (state_reg == IDLE) || (valid_reg && bus.grant_ready);

   // State, pointer and output registers; everything changes only at a decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         valid_reg  <= 1'b0;
         idx_reg    <= '0;
         onehot_reg <= '0;
      end else if (decision) begin
         if (pick_found) begin
            state_reg  <= GRANT;
            valid_reg  <= 1'b1;
            idx_reg    <= win_idx;
            onehot_reg <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            ptr_reg    <= win_idx;
         end else begin
            // idx keeps its last value on the way back to IDLE.
            state_reg  <= IDLE;
            valid_reg  <= 1'b0;
            onehot_reg <= '0;
         end
      end
   end

   assign bus.grant_valid  = valid_reg;
   assign bus.grant_idx    = idx_reg;
   assign bus.grant_onehot = onehot_reg;

endmodule

// File: doc/pe_rr_arbiter.md
# pe_rr_arbiter

Parametrised priority encoder/arbiter. It turns an N-bit request vector into a registered grant index and a one-hot grant, held under a valid/ready handshake. Two modes are selectable at run time: fixed priority (highest index wins) and round-robin (rotating priority, for fairness). It sits between request sources and a shared resource, and is the sequential successor of the team's combinational 8:3 encoder.

## Interface
- `N`, default 8: number of request lines; N ≥ 2, need not be a power of two.
- `W`, default `$clog2(N)`: index width; derived, not overridden.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mode`  in  1: 0 = fixed priority, 1 = round-robin; sampled only at a decision cycle.
- `req`  in  N: level request vector, bit i = requester i.
- `grant_ready`  in  1: consumer accepts the current grant.
- `grant_valid`  out  1: grant_idx/grant_onehot hold a valid grant.
- `grant_idx`  out  W: granted requester index.
- `grant_onehot`  out  N: one-hot form of grant_idx; all zero when grant_valid = 0.

## Operation
- Reset values: grant_valid = 0, grant_idx = 0, grant_onehot = 0, rotation pointer ptr = 0, state = IDLE.
- States:
  - IDLE: no grant outstanding.
  - GRANT: grant_valid = 1, outputs frozen.
- Decision cycle: any cycle in IDLE, or any cycle in GRANT where grant_valid & grant_ready. At a decision cycle, req and mode are evaluated and the result is registered.
- Fixed mode: the winner is the highest set bit of req. Bit N-1 has the highest priority and bit 0 the lowest, matching the 8:3 encoder.
- Round-robin mode:
  - Search order is ptr-1, ptr-2, …, 0, N-1, …, ptr (modulo N); the first set bit wins.
  - ptr holds the last granted index. With ptr = 0 the order equals fixed priority.
- ptr updates to the winning index on every issued grant, in both modes. A mode switch therefore continues rotation from the last grant.
- Transitions:
  - IDLE, req ≠ 0 → GRANT with the winner.
  - IDLE, req = 0 → IDLE.
  - GRANT, ready = 0 → GRANT, outputs unchanged.
  - GRANT, ready = 1, req ≠ 0 → GRANT with a new winner (back-to-back).
  - GRANT, ready = 1, req = 0 → IDLE.
- When going to IDLE, grant_onehot clears to 0 and grant_idx keeps its last value.
- The requester of the current grant is not masked. If it is still requesting at acceptance, it competes normally: it wins again in fixed mode and has lowest priority in round-robin.
- req changes while in GRANT with ready = 0 are ignored.
- For non-power-of-two N, the pointer wraps at N-1 → 0. Index values ≥ N are never produced.

## Timing
- Latency: one cycle, from a decision-cycle req to grant_valid/grant_idx.
- Throughput: one grant per cycle when grant_ready is held at 1 and req is nonzero.
- All outputs are registered. There is no combinational path from req/ready to outputs.
- rst asserts outputs asynchronously. Release is synchronous to clk; the first decision is at the first clk edge after release.
- A reset during GRANT drops grant_valid immediately. The pending grant is lost and ptr returns to 0.

## Structure
- Package `pe_pkg`:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - State enum IDLE/GRANT.
- Sub-module `pe_prio_pick #(N)`: combinational highest-set-bit finder giving index + found flag.
  - Round-robin is implemented by rotating req by ptr before the picker and un-rotating the index after, modulo N.
  - The same instance serves fixed mode with zero rotation.
- Top holds the state register, ptr and output registers.

## Test plan
- Reset: rst = 1 with req = 8'hFF. Required: grant_valid = 0, grant_onehot = 0, grant_idx = 0. After release with ready = 1, the first grant is idx 7.
- Fixed priority, N = 8, mode = 0, req = 8'b0010_0110, ready = 1. Required: next cycle idx = 5, onehot = 8'b0010_0000. With req held, idx stays 5 every cycle.
- Backpressure: grant idx 5 outstanding, ready = 0, req changes to 8'b1000_0000 for 3 cycles. Required: idx stays 5 and valid stays 1. After ready = 1 for one cycle, the next grant is idx 7.
- Round-robin sweep, mode = 1, req = 8'hFF, ready = 1 from reset. Required grant sequence: 7, 6, 5, 4, 3, 2, 1, 0, 7.
- Round-robin wrap: ptr = 2 (last grant 2), req = 8'b0000_0101, ready = 1. Required: next grant 0, then 2, then 0 (alternating). With N = 5 and req = 5'b10001 the grants alternate 4, 0.
- Mid-operation reset: assert rst while grant_valid = 1. Required: valid/onehot go to 0 without waiting for a clock edge. After release with req = 8'b0000_0011 in mode 1, the first grant is idx 1 (ptr was reset to 0).
